// File: rtl/axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite manager port among NUM_REQ requesters.
// Exactly one read or write is in flight at a time; every output is driven from a register.
module axi4_lite_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH/8-1:0]       wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [2:0]                    arprot,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  output logic                          rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts at ptr_q and wraps, so the most recently served requester is checked last.
  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [IDW:0]   cand;
  logic [IDW:0]   ptr_inc;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!arb_found && req_valid[cand[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDW-1:0];
      end
    end
    ptr_inc = {1'b0, arb_idx} + 1'b1;
    if (ptr_inc == (IDW+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
  end

  logic aw_fin, w_fin;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_fin      = aw_done_q | (awvalid_q & awready);
    w_fin       = w_done_q | (wvalid_q & wready);

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          req_ready_d[arb_idx] = 1'b1;
          grant_d              = arb_idx;
          ptr_d                = ptr_inc[IDW-1:0];
          if (req_write[arb_idx]) begin
            awaddr_d  = addr_arr[arb_idx];
            wdata_d   = wdata_arr[arb_idx];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = AW_W;
          end else begin
            araddr_d  = addr_arr[arb_idx];
            arvalid_d = 1'b1;
            state_d   = AR;
          end
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          rready_d             = 1'b0;
          rsp_rdata_d          = rdata;
          rsp_err_d            = |rresp;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = IDLE;
        end
      end
      AW_W: begin
        // Address and data channels complete independently, in either order or together.
        awvalid_d = ~aw_fin;
        wvalid_d  = ~w_fin;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = B;
        end
      end
      B: begin
        if (bvalid) begin
          bready_d             = 1'b0;
          rsp_err_d            = |bresp;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign awaddr    = awaddr_q;
  assign awprot    = 3'b000;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = '1;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arprot    = 3'b000;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule
